// File: rtl/input_arbiter.sv
// Two-source command arbiter (manual/auto) for the kitchen game: fixed hold, one-cycle gap, starvation guard.
// Optional forced release of a stuck owner is compiled in with `define ARB_TIMEOUT_EN.
module input_arbiter #(
  parameter int HOLD_CYC   = 4,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_man,
  input  logic [7:0] cmd_man,
  input  logic       req_auto,
  input  logic [7:0] cmd_auto,
  input  logic       mode_auto,
  output logic [7:0] in_bits,
  output logic       gnt_man,
  output logic       gnt_auto,
  output logic       done_man,
  output logic       done_auto,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] state_arb
);
  localparam int CNT_MAX = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SW_RAW  = $clog2(STARVE_MAX + 1);
  localparam int ST_W    = (SW_RAW > 2) ? SW_RAW : 2;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);
`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_owner, w_owner_next;          // 1 = auto owns the bus
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_past_hold, w_past_next;
  logic [ST_W-1:0]   r_starve, w_starve_next, w_starve_eff;
  logic              r_mode_prev;
  logic              r_force_valid, w_force_next;
  logic              r_force_src, w_force_src_next;
  logic [7:0]        r_in_bits, w_in_bits_next;
  logic              r_gnt_man, r_gnt_auto, r_done_man, r_done_auto, r_busy, r_timeout;
  logic              w_done_next, w_timeout_next, w_win_auto, w_owner_req, w_other_req;

  // A preference flip restarts fairness accounting from scratch.
  assign w_starve_eff = (mode_auto != r_mode_prev) ? '0 : r_starve;

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_cnt_next       = r_cnt;
    w_past_next      = r_past_hold;
    w_starve_next    = w_starve_eff;
    w_force_next     = r_force_valid;
    w_force_src_next = r_force_src;
    w_in_bits_next   = 8'h00;
    w_done_next      = 1'b0;
    w_timeout_next   = 1'b0;
    w_win_auto       = 1'b0;
    w_owner_req      = r_owner ? req_auto : req_man;
    w_other_req      = mode_auto ? req_man : req_auto;

    case (r_state)
      ST_IDLE: begin
        if (req_man || req_auto) begin
          if (req_man && req_auto) begin
            if (r_force_valid)                  w_win_auto = r_force_src;
            else if (w_starve_eff == STARVE_LIM) w_win_auto = ~mode_auto;
            else                                 w_win_auto = mode_auto;
          end else begin
            w_win_auto = req_auto;
          end
          if ((w_win_auto == mode_auto) && w_other_req)
            w_starve_next = (w_starve_eff < STARVE_LIM) ? w_starve_eff + ST_W'(1) : STARVE_LIM;
          else
            w_starve_next = '0;
          w_force_next   = 1'b0;
          w_state_next   = ST_GRANT;
          w_owner_next   = w_win_auto;
          w_cnt_next     = '0;
          w_past_next    = 1'b0;
          w_in_bits_next = w_win_auto ? cmd_auto : cmd_man;
        end
      end

      ST_GRANT: begin
        w_in_bits_next = r_in_bits;
        if (!r_past_hold) begin
          if (r_cnt < HOLD_LAST) begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end else if (!w_owner_req) begin
            w_state_next = ST_GAP;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            w_past_next = 1'b1;
            w_cnt_next  = '0;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (!w_owner_req) begin
          w_state_next = ST_GAP;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_next     = ST_GAP;
          w_timeout_next   = 1'b1;
          w_force_next     = 1'b1;
          w_force_src_next = ~r_owner;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
`endif
        if (w_state_next == ST_GAP) begin
          w_in_bits_next = 8'h00;
          w_done_next    = 1'b1;
          w_cnt_next     = '0;
          w_past_next    = 1'b0;
        end
      end

      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_past_hold   <= 1'b0;
      r_starve      <= '0;
      r_mode_prev   <= 1'b0;
      r_force_valid <= 1'b0;
      r_force_src   <= 1'b0;
      r_in_bits     <= 8'h00;
      r_gnt_man     <= 1'b0;
      r_gnt_auto    <= 1'b0;
      r_done_man    <= 1'b0;
      r_done_auto   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_owner       <= w_owner_next;
      r_cnt         <= w_cnt_next;
      r_past_hold   <= w_past_next;
      r_starve      <= w_starve_next;
      r_mode_prev   <= mode_auto;
      r_force_valid <= w_force_next;
      r_force_src   <= w_force_src_next;
      r_in_bits     <= w_in_bits_next;
      r_gnt_man     <= (w_state_next == ST_GRANT) && !w_owner_next;
      r_gnt_auto    <= (w_state_next == ST_GRANT) && w_owner_next;
      r_done_man    <= w_done_next && !r_owner;
      r_done_auto   <= w_done_next && r_owner;
      r_busy        <= (w_state_next != ST_IDLE);
      r_timeout     <= w_timeout_next;
    end
  end

  assign in_bits   = r_in_bits;
  assign gnt_man   = r_gnt_man;
  assign gnt_auto  = r_gnt_auto;
  assign done_man  = r_done_man;
  assign done_auto = r_done_auto;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign state_arb = r_state;
endmodule

// File: tb/tb_input_arbiter.sv
// Directed self-checking bench for input_arbiter; outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_input_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_man, req_auto, mode_auto;
  logic [7:0] cmd_man, cmd_auto;
  logic [7:0] in_bits;
  logic       gnt_man, gnt_auto, done_man, done_auto, busy, timeout;
  logic [1:0] state_arb;

  int n_checks = 0;
  int n_err    = 0;

  input_arbiter #(.HOLD_CYC(4), .STARVE_MAX(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_man(req_man), .cmd_man(cmd_man),
    .req_auto(req_auto), .cmd_auto(cmd_auto),
    .mode_auto(mode_auto),
    .in_bits(in_bits), .gnt_man(gnt_man), .gnt_auto(gnt_auto),
    .done_man(done_man), .done_auto(done_auto),
    .busy(busy), .timeout(timeout), .state_arb(state_arb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && state_arb != 2'd0; k++) @(negedge clk);
    chk(tag, state_arb, 0);
  endtask

  int g_src[5];
  int g_t[5];
  int ng;
  int exp_src[5] = '{1, 1, 1, 0, 1};
  logic prev_man, prev_auto, any_to;
  int t_g, t_to;

  initial begin
    // Reset overrides simultaneous requests
    rst = 1; req_man = 1; req_auto = 1; mode_auto = 0; cmd_man = 8'h11; cmd_auto = 8'h22;
    repeat (3) @(negedge clk);
    chk("rst_state", state_arb, 0);
    chk("rst_in_bits", in_bits, 8'h00);
    chk("rst_gnt", {gnt_man, gnt_auto}, 0);
    chk("rst_done", {done_man, done_auto}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 0; req_man = 0; req_auto = 0;
    @(negedge clk);
    chk("idle_after_rst", state_arb, 0);

    // Single manual request: 4 cycles of 8'h27, then GAP with done_man
    req_man = 1; cmd_man = 8'h27;
    @(negedge clk);
    req_man = 0; cmd_man = 8'h55;
    for (int i = 0; i < 4; i++) begin
      $display("man_single cycle %0d: gnt_man=%0b in_bits=%02h", i, gnt_man, in_bits);
      chk("man_gnt", gnt_man, 1);
      chk("man_in_bits", in_bits, 8'h27);
      chk("man_busy", busy, 1);
      @(negedge clk);
    end
    chk("man_gap_state", state_arb, 2);
    chk("man_gap_in_bits", in_bits, 8'h00);
    chk("man_gap_done", done_man, 1);
    chk("man_gap_gnt", gnt_man, 0);
    @(negedge clk);
    chk("man_back_idle", state_arb, 0);
    chk("man_done_one_cycle", done_man, 0);

    // cmd_auto change mid-GRANT is ignored
    mode_auto = 1; req_auto = 1; cmd_auto = 8'h1F;
    @(negedge clk);
    chk("auto_gnt", gnt_auto, 1);
    chk("auto_in_bits0", in_bits, 8'h1F);
    cmd_auto = 8'h2B;
    @(negedge clk);
    chk("auto_in_bits1", in_bits, 8'h1F);
    req_auto = 0;
    @(negedge clk);
    chk("auto_in_bits2", in_bits, 8'h1F);
    @(negedge clk);
    chk("auto_in_bits3", in_bits, 8'h1F);
    @(negedge clk);
    $display("auto_hold gap: done_auto=%0b in_bits=%02h", done_auto, in_bits);
    chk("auto_gap_done", done_auto, 1);
    chk("auto_gap_in_bits", in_bits, 8'h00);
    @(negedge clk);
    chk("auto_back_idle", state_arb, 0);

    // Reset on the 2nd GRANT cycle aborts without done
    mode_auto = 0; req_man = 1; cmd_man = 8'h44;
    @(negedge clk);
    req_man = 0;
    chk("abort_first_gnt", gnt_man, 1);
    @(negedge clk);
    chk("abort_second_gnt", state_arb, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    $display("abort: state=%0d in_bits=%02h done_man=%0b", state_arb, in_bits, done_man);
    chk("abort_in_bits", in_bits, 8'h00);
    chk("abort_state", state_arb, 0);
    chk("abort_gnt", gnt_man, 0);
    chk("abort_done", done_man, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_man, 0);
    end

    // Both requesting, auto preferred; each source drops req while it owns the bus
    mode_auto = 1; req_man = 1; req_auto = 1;
    ng = 0; prev_man = 0; prev_auto = 0;
    for (int t = 1; t <= 40 && ng < 5; t++) begin
      @(negedge clk);
      if (gnt_auto && !prev_auto) begin g_src[ng] = 1; g_t[ng] = t; ng++; end
      else if (gnt_man && !prev_man) begin g_src[ng] = 0; g_t[ng] = t; ng++; end
      prev_man = gnt_man; prev_auto = gnt_auto;
      req_man = ~gnt_man; req_auto = ~gnt_auto;
    end
    req_man = 0; req_auto = 0;
    chk("starve_grant_count", ng, 5);
    for (int k = 0; k < ng; k++) begin
      $display("starve grant %0d: src=%s t=%0d", k, g_src[k] ? "auto" : "man", g_t[k]);
      chk("starve_order", g_src[k], exp_src[k]);
      if (k > 0) chk("starve_spacing", g_t[k] - g_t[k-1], 6);
    end
    wait_idle("starve_idle");

`ifdef ARB_TIMEOUT_EN
    // Stuck manual owner is forced out; auto then wins the next arbitration
    @(negedge clk);
    mode_auto = 0; req_man = 1; req_auto = 1; cmd_man = 8'h66; cmd_auto = 8'h77;
    t_g = -1; t_to = -1;
    for (int c = 1; c <= 40 && t_to < 0; c++) begin
      @(negedge clk);
      if (gnt_man && t_g < 0) t_g = c;
      if (timeout) begin
        t_to = c;
        chk("to_done_same_cycle", done_man, 1);
      end
    end
    $display("timeout: grant at %0d, timeout at %0d", t_g, t_to);
    chk("to_delay", t_to - t_g, 12);
    @(negedge clk);
    chk("to_timeout_one_cycle", timeout, 0);
    @(negedge clk);
    chk("to_next_owner_auto", gnt_auto, 1);
    chk("to_next_in_bits", in_bits, 8'h77);
    req_man = 0; req_auto = 0;
    wait_idle("to_idle");
`else
    // Stuck manual owner keeps the grant indefinitely
    @(negedge clk);
    mode_auto = 0; req_man = 1; req_auto = 0; cmd_man = 8'h66;
    any_to = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (timeout) any_to = 1;
      if (c % 100 == 0) begin
        $display("stuck cycle %0d: gnt_man=%0b timeout=%0b", c, gnt_man, timeout);
        chk("stuck_gnt", gnt_man, 1);
        chk("stuck_in_bits", in_bits, 8'h66);
      end
    end
    chk("stuck_no_timeout", any_to, 0);
    req_man = 0;
    @(negedge clk);
    chk("stuck_release_gap", state_arb, 2);
    chk("stuck_release_done", done_man, 1);
    wait_idle("stuck_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/input_arbiter.md
INPUT_ARBITER -- requirements
Module: input_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 4: minimum cycles a granted command is driven on in_bits.
REQ-002 Parameter STARVE_MAX, default 3: consecutive preferred-source grants allowed while the other source waits.
REQ-003 Parameter TIMEOUT, default 255: cycles past the hold phase before a forced release; used only with ARB_TIMEOUT_EN.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req_man and cmd_man, inputs, 1 and 8: manual-mode request and its 8-bit game command.
REQ-007 Port req_auto and cmd_auto, inputs, 1 and 8: automatic-mode request and its 8-bit game command.
REQ-008 Port mode_auto, input, 1: preferred source select; 1 = auto preferred, 0 = manual preferred.
REQ-009 Port in_bits, output, 8: command driven to the kitchen game; 8'h00 means no action.
REQ-010 Port gnt_man and gnt_auto, outputs, 1 each: the owning source is granted.
REQ-011 Port done_man and done_auto, outputs, 1 each: one-cycle completion pulse to the owner.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port timeout, output, 1: one-cycle forced-release pulse.
REQ-014 Port state_arb, output, 2: current state code; IDLE=0, GRANT=1, GAP=2.

Function
REQ-015 States SHALL be IDLE, GRANT and GAP; every output SHALL be registered.
REQ-016 IDLE: on a cycle with any req high, the block SHALL enter GRANT next cycle and latch the winner's cmd; gnt_x and in_bits SHALL be valid in that cycle (latency 1).
REQ-017 Arbitration: one requester wins; if both request, the mode_auto-preferred source wins unless the starvation count equals STARVE_MAX, in which case the other source wins.
REQ-018 Starvation count (2 bits min): +1 when the preferred source wins while the other req is high; cleared on a grant to the non-preferred source or when the other req is low at grant time; it saturates at STARVE_MAX.
REQ-019 A change of mode_auto SHALL clear the starvation count and never affect the current owner.
REQ-020 GRANT: in_bits SHALL hold the latched cmd, and cmd input changes SHALL be ignored; hold counter counts from 0.
REQ-021 GRANT exit: when hold count >= HOLD_CYC-1 and the owner's req is low, the next state SHALL be GAP.
REQ-022 If the owner's req drops before HOLD_CYC cycles, the block SHALL still drive in_bits for the full HOLD_CYC cycles.
REQ-023 GAP: lasts exactly one cycle with in_bits=8'h00 and gnt low; the owner's done pulses in this cycle; next state is IDLE.
REQ-024 Back-to-back: with req held continuously, grants SHALL start at most every HOLD_CYC+2 cycles.
REQ-025 A non-owner request arriving during GRANT or GAP SHALL wait and be arbitrated in IDLE.
REQ-026 Hold counter width SHALL be ceil(log2(max(HOLD_CYC,TIMEOUT)+1)) bits, with no wrap-around.

Reset
REQ-027 When rst is high at a clock edge: state=IDLE; in_bits=8'h00; gnt, done, busy and timeout all 0; counters 0; state_arb=0.
REQ-028 rst SHALL override all simultaneous requests.
REQ-029 rst during GRANT SHALL abort the command with no done pulse.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined: if the owner's req stays high for TIMEOUT cycles after the hold phase, go to GAP, pulse timeout with done, and give the next IDLE arbitration to the other source if it is requesting.
REQ-031 Without ARB_TIMEOUT_EN: GRANT lasts indefinitely while the owner's req is high, and timeout is constant 0.

Verification
REQ-032 req_man=1 for 1 cycle, cmd_man=8'h27, mode_auto=0 -> gnt_man and in_bits=8'h27 for 4 cycles, then in_bits=8'h00 with done_man for 1 cycle.
REQ-033 Both req high and held, mode_auto=1 -> grant order auto,auto,auto,man,auto, each grant 6 cycles apart.
REQ-034 cmd_auto changes from 8'h1F to 8'h2B mid-GRANT -> in_bits stays 8'h1F.
REQ-035 rst on the 2nd GRANT cycle -> next cycle in_bits=8'h00, state_arb=0, and no done pulse.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT=8, req_man stuck high -> timeout and done_man pulse on the same cycle, 12 cycles after the grant.
REQ-037 Without ARB_TIMEOUT_EN, req_man stuck high for 1000 cycles -> gnt_man stays high and timeout stays 0.
